// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types plus the hazard controller's state encoding and
// the instruction field positions used for operand compares.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    localparam regbits_t REG_ZERO = 5'd0;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_WAIT  = 2'd1,
        BR_FLUSH = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/hazard_fwd_prio.sv
// Priority encoder picking the youngest forwarding source that writes the
// requested register; $0 never matches, so it always reads the register file.
module hazard_fwd_prio
    import cpu_types_pkg::*;
#(
    parameter  int NFWD  = 2,
    localparam int FSELW = $clog2(NFWD + 1)
) (
    input  regbits_t               src,
    input  logic [NFWD*5-1:0]      wsel_fwd,
    input  logic [NFWD-1:0]        RegWrite_fwd,
    output logic [FSELW-1:0]       fsel
);

    // Oldest first, so a younger match overwrites an older one.
    always_comb begin
        fsel = '0;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (RegWrite_fwd[k] &&
                wsel_fwd[k*5 +: 5] != REG_ZERO &&
                wsel_fwd[k*5 +: 5] == src) begin
                fsel = FSELW'(k + 1);
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: EX operand forwarding, load-use bubbles and
// branch flushes that survive instruction-memory wait cycles.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | normal flow; reacts to branch_taken or a load-use hazard
// LU_WAIT  | inserting the remaining load-use bubbles (count in bub)
// BR_FLUSH | branch flush waiting for ihit before it can complete
module hazard_ctrl_unit
    import cpu_types_pkg::*;
#(
    parameter  int NFWD       = 2,
    parameter  int LU_BUBBLES = 1,
    parameter  int CNTW       = 16,
    localparam int FSELW      = $clog2(NFWD + 1)
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               ihit,
    input  word_t              instr_id,
    input  word_t              instr_ex,
    input  logic               MemRead_ex,
    input  regbits_t           wsel_ex,
    input  logic [NFWD*5-1:0]  wsel_fwd,
    input  logic [NFWD-1:0]    RegWrite_fwd,
    input  logic               branch_taken,
    output logic [FSELW-1:0]   forwardA,
    output logic [FSELW-1:0]   forwardB,
    output logic               pc_stall,
    output logic               ifid_stall,
    output logic               idex_flush,
    output logic               ifid_flush,
    output logic               exmem_flush,
    output logic [CNTW-1:0]    stall_cnt,
    output logic [CNTW-1:0]    flush_cnt
);

    localparam logic [2:0]      BUB_RELOAD = 3'(LU_BUBBLES - 1);
    localparam logic [CNTW-1:0] CNT_MAX    = '1;

    hazard_state_t state, state_nxt;
    logic [2:0]    bub, bub_nxt;

    regbits_t ex_rs, ex_rt, id_rs, id_rt;
    logic     adv, luse;
    logic     stall_c, flush_c, stall_inc, flush_inc;
    logic     unused_instr_bits;

    assign ex_rs = instr_ex[RS_MSB:RS_LSB];
    assign ex_rt = instr_ex[RT_MSB:RT_LSB];
    assign id_rs = instr_id[RS_MSB:RS_LSB];
    assign id_rt = instr_id[RT_MSB:RT_LSB];
    assign unused_instr_bits = ^{instr_ex[31:26], instr_ex[15:0],
                                 instr_id[31:26], instr_id[15:0]};

    hazard_fwd_prio #(.NFWD(NFWD)) u_fwd_rs (
        .src          (ex_rs),
        .wsel_fwd     (wsel_fwd),
        .RegWrite_fwd (RegWrite_fwd),
        .fsel         (forwardA)
    );

    hazard_fwd_prio #(.NFWD(NFWD)) u_fwd_rt (
        .src          (ex_rt),
        .wsel_fwd     (wsel_fwd),
        .RegWrite_fwd (RegWrite_fwd),
        .fsel         (forwardB)
    );

    assign adv  = ihit;
    assign luse = MemRead_ex && (wsel_ex != REG_ZERO) &&
                  (wsel_ex == id_rs || wsel_ex == id_rt);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
            bub   <= '0;
        end else begin
            state <= state_nxt;
            bub   <= bub_nxt;
        end
    end

    // A pending flush outranks everything; a branch also preempts bubbles.
    always_comb begin
        state_nxt = state;
        bub_nxt   = bub;
        stall_c   = 1'b0;
        flush_c   = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (state == BR_FLUSH) begin
            flush_c = 1'b1;
            if (adv) begin
                flush_inc = 1'b1;
                state_nxt = RUN;
            end
        end else if (branch_taken) begin
            flush_c = 1'b1;
            if (adv) begin
                flush_inc = 1'b1;
                state_nxt = RUN;
            end else begin
                state_nxt = BR_FLUSH;
            end
        end else if (state == LU_WAIT) begin
            stall_c = 1'b1;
            if (adv) begin
                stall_inc = 1'b1;
                bub_nxt   = bub - 3'd1;
                if (bub == 3'd1) begin
                    state_nxt = RUN;
                end
            end
        end else if (luse) begin
            stall_c = 1'b1;
            if (adv) begin
                stall_inc = 1'b1;
                if (LU_BUBBLES > 1) begin
                    bub_nxt   = BUB_RELOAD;
                    state_nxt = LU_WAIT;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNTW'(1);
            end
            if (flush_inc && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + CNTW'(1);
            end
        end
    end

    // Reset must silence the controls at once, even with hazards on the inputs.
    assign pc_stall    = nRST & stall_c;
    assign ifid_stall  = nRST & stall_c;
    assign idex_flush  = nRST & (stall_c | flush_c);
    assign ifid_flush  = nRST & flush_c;
    assign exmem_flush = nRST & flush_c;

endmodule
